// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external combinational ALU
// between two requesters, one operation in flight at a time. Rev 1.0
`default_nettype none

module alu_arbiter #(
   parameter int WIDTH   = 11,
   parameter int FUNCT_W = 4
) (
   input  logic               clk,
   input  logic               reset_n,

   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [FUNCT_W-1:0] req0_funct,
   input  logic [WIDTH-1:0]   req0_a,
   input  logic [WIDTH-1:0]   req0_b,

   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [FUNCT_W-1:0] req1_funct,
   input  logic [WIDTH-1:0]   req1_a,
   input  logic [WIDTH-1:0]   req1_b,

   output logic               rsp0_valid,
   input  logic               rsp0_ready,
   output logic [WIDTH-1:0]   rsp0_data,
   output logic               rsp0_zero,
   output logic               rsp0_overflow,

   output logic               rsp1_valid,
   input  logic               rsp1_ready,
   output logic [WIDTH-1:0]   rsp1_data,
   output logic               rsp1_zero,
   output logic               rsp1_overflow,

   output logic [WIDTH-1:0]   alu_in0,
   output logic [WIDTH-1:0]   alu_in1,
   output logic [FUNCT_W-1:0] alu_funct,
   input  logic [WIDTH-1:0]   alu_out,
   input  logic               alu_zero,
   input  logic               alu_overflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [FUNCT_W-1:0] C_FIRST_ILLEGAL = FUNCT_W'(6);

   state_t               state_q,      state_d;
   logic                 owner_q,      owner_d;
   logic                 last_grant_q, last_grant_d;
   logic [FUNCT_W-1:0]   funct_q,      funct_d;
   logic [WIDTH-1:0]     a_q,          a_d;
   logic [WIDTH-1:0]     b_q,          b_d;
   logic [WIDTH-1:0]     rsp0_data_q,  rsp0_data_d;
   logic                 rsp0_zero_q,  rsp0_zero_d;
   logic                 rsp0_ovf_q,   rsp0_ovf_d;
   logic [WIDTH-1:0]     rsp1_data_q,  rsp1_data_d;
   logic                 rsp1_zero_q,  rsp1_zero_d;
   logic                 rsp1_ovf_q,   rsp1_ovf_d;

   logic                 w_grant;
   logic                 w_grant_id;
   logic                 w_illegal;
   logic [WIDTH-1:0]     w_res_data;
   logic                 w_res_zero;
   logic                 w_res_ovf;
   logic                 w_owner_rsp_ready;

   // On a tie, favour whoever did not win last; otherwise the lone requester.
   assign w_grant    = (state_q == IDLE) && (req0_valid || req1_valid);
   assign w_grant_id = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

   assign w_illegal  = (funct_q >= C_FIRST_ILLEGAL);
   assign w_res_data = w_illegal ? '0 : alu_out;
   assign w_res_zero = w_illegal | alu_zero;
   assign w_res_ovf  = ~w_illegal & alu_overflow;

   assign w_owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      funct_d      = funct_q;
      a_d          = a_q;
      b_d          = b_q;
      rsp0_data_d  = rsp0_data_q;
      rsp0_zero_d  = rsp0_zero_q;
      rsp0_ovf_d   = rsp0_ovf_q;
      rsp1_data_d  = rsp1_data_q;
      rsp1_zero_d  = rsp1_zero_q;
      rsp1_ovf_d   = rsp1_ovf_q;

      case (state_q)
         IDLE: begin
            if (w_grant) begin
               state_d      = EXEC;
               owner_d      = w_grant_id;
               last_grant_d = w_grant_id;
               funct_d      = w_grant_id ? req1_funct : req0_funct;
               a_d          = w_grant_id ? req1_a     : req0_a;
               b_d          = w_grant_id ? req1_b     : req0_b;
            end
         end
         EXEC: begin
            state_d = RESP;
            if (owner_q) begin
               rsp1_data_d = w_res_data;
               rsp1_zero_d = w_res_zero;
               rsp1_ovf_d  = w_res_ovf;
            end else begin
               rsp0_data_d = w_res_data;
               rsp0_zero_d = w_res_zero;
               rsp0_ovf_d  = w_res_ovf;
            end
         end
         RESP: begin
            if (w_owner_rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         funct_q      <= '0;
         a_q          <= '0;
         b_q          <= '0;
         rsp0_data_q  <= '0;
         rsp0_zero_q  <= 1'b0;
         rsp0_ovf_q   <= 1'b0;
         rsp1_data_q  <= '0;
         rsp1_zero_q  <= 1'b0;
         rsp1_ovf_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         funct_q      <= funct_d;
         a_q          <= a_d;
         b_q          <= b_d;
         rsp0_data_q  <= rsp0_data_d;
         rsp0_zero_q  <= rsp0_zero_d;
         rsp0_ovf_q   <= rsp0_ovf_d;
         rsp1_data_q  <= rsp1_data_d;
         rsp1_zero_q  <= rsp1_zero_d;
         rsp1_ovf_q   <= rsp1_ovf_d;
      end
   end

   // Ready is combinational from live inputs, so it must be masked while reset is held.
   assign req0_ready    = reset_n & w_grant & ~w_grant_id;
   assign req1_ready    = reset_n & w_grant &  w_grant_id;

   assign rsp0_valid    = (state_q == RESP) && !owner_q;
   assign rsp1_valid    = (state_q == RESP) &&  owner_q;
   assign rsp0_data     = rsp0_data_q;
   assign rsp0_zero     = rsp0_zero_q;
   assign rsp0_overflow = rsp0_ovf_q;
   assign rsp1_data     = rsp1_data_q;
   assign rsp1_zero     = rsp1_zero_q;
   assign rsp1_overflow = rsp1_ovf_q;

   assign alu_in0       = a_q;
   assign alu_in1       = b_q;
   assign alu_funct     = funct_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a
// transaction-level model; the bench also plays the role of the shared ALU.
`default_nettype none

module tb_alu_arbiter;

   localparam int W    = 11;
   localparam int F    = 4;
   localparam int MAXS = (1 << (W - 1)) - 1;
   localparam int MINS = -(1 << (W - 1));

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [F-1:0] req0_funct = '0, req1_funct = '0;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic         rsp0_valid, rsp1_valid;
   logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [W-1:0] rsp0_data, rsp1_data;
   logic         rsp0_zero, rsp0_overflow, rsp1_zero, rsp1_overflow;
   logic [W-1:0] alu_in0, alu_in1, alu_out;
   logic [F-1:0] alu_funct;
   logic         alu_zero, alu_overflow;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(W), .FUNCT_W(F)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct(req0_funct),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct(req1_funct),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
      .rsp0_zero(rsp0_zero), .rsp0_overflow(rsp0_overflow),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
      .rsp1_zero(rsp1_zero), .rsp1_overflow(rsp1_overflow),
      .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_funct(alu_funct),
      .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow)
   );

   // ALU behaviour in signed integer arithmetic; returns {data, zero, overflow}.
   // Unknown codes return deliberate garbage that the arbiter must ignore.
   function automatic logic [W+1:0] alu_fn(input logic [F-1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      int          sa, sb, r;
      longint      p;
      logic [W-1:0] d;
      logic        o;
      sa = int'($signed(a));
      sb = int'($signed(b));
      o  = 1'b0;
      d  = '0;
      case (int'(f))
         0: begin r = sa + sb; d = W'(r); o = (r > MAXS) || (r < MINS); end
         1: begin r = sa - sb; d = W'(r); o = (r > MAXS) || (r < MINS); end
         2: begin p = longint'(a) * longint'(b); d = W'(p); o = (p >= (64'sd1 <<< W)); end
         3: d = ~a;
         4: d = (sa < sb) ? W'(1) : W'(0);
         5: d = (sa > sb) ? W'(1) : W'(0);
         default: return {a ^ b, 1'b0, 1'b1};
      endcase
      return {d, (d == '0), o};
   endfunction

   function automatic logic [W+1:0] expect_fn(input logic [F-1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      if (int'(f) >= 6) return {{W{1'b0}}, 1'b1, 1'b0};
      return alu_fn(f, a, b);
   endfunction

   assign {alu_out, alu_zero, alu_overflow} = alu_fn(alu_funct, alu_in0, alu_in1);

   // Transaction model: at most one op; age 0 is the execute cycle, age >= 1 is responding.
   bit           m_busy;
   int           m_age, m_owner, m_last;
   logic [W-1:0] m_a, m_b;
   logic [F-1:0] m_f;
   logic [W+1:0] m_res;

   function automatic int exp_grant();
      if (!reset_n || m_busy) return -1;
      if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
      if (req0_valid) return 0;
      if (req1_valid) return 1;
      return -1;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_busy <= 1'b0; m_age <= 0; m_owner <= 0; m_last <= 1;
         m_a <= '0; m_b <= '0; m_f <= '0; m_res <= '0;
      end else if (!m_busy) begin
         case (exp_grant())
            0: begin
               m_busy <= 1'b1; m_age <= 0; m_owner <= 0; m_last <= 0;
               m_a <= req0_a; m_b <= req0_b; m_f <= req0_funct;
               m_res <= expect_fn(req0_funct, req0_a, req0_b);
            end
            1: begin
               m_busy <= 1'b1; m_age <= 0; m_owner <= 1; m_last <= 1;
               m_a <= req1_a; m_b <= req1_b; m_f <= req1_funct;
               m_res <= expect_fn(req1_funct, req1_a, req1_b);
            end
            default: ;
         endcase
      end else if (m_age == 0) begin
         m_age <= 1;
      end else if ((m_owner == 0) ? rsp0_ready : rsp1_ready) begin
         m_busy <= 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : p_compare
      int  g;
      bit  v0, v1;
      if (chk_on) begin
         g  = exp_grant();
         v0 = reset_n && m_busy && (m_age >= 1) && (m_owner == 0);
         v1 = reset_n && m_busy && (m_age >= 1) && (m_owner == 1);
         chk("req0_ready", req0_ready, (g == 0));
         chk("req1_ready", req1_ready, (g == 1));
         chk("rsp0_valid", rsp0_valid, v0);
         chk("rsp1_valid", rsp1_valid, v1);
         chk("alu_in0", alu_in0, m_a);
         chk("alu_in1", alu_in1, m_b);
         chk("alu_funct", alu_funct, m_f);
         if (v0) begin
            chk("rsp0_data", rsp0_data, m_res[W+1:2]);
            chk("rsp0_zero", rsp0_zero, m_res[1]);
            chk("rsp0_overflow", rsp0_overflow, m_res[0]);
         end
         if (v1) begin
            chk("rsp1_data", rsp1_data, m_res[W+1:2]);
            chk("rsp1_zero", rsp1_zero, m_res[1]);
            chk("rsp1_overflow", rsp1_overflow, m_res[0]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_req0_ready"}, req0_ready, 0);
      chk({pfx, "_req1_ready"}, req1_ready, 0);
      chk({pfx, "_rsp0_valid"}, rsp0_valid, 0);
      chk({pfx, "_rsp1_valid"}, rsp1_valid, 0);
      chk({pfx, "_rsp0_data"}, rsp0_data, 0);
      chk({pfx, "_rsp0_flags"}, {rsp0_zero, rsp0_overflow}, 0);
      chk({pfx, "_rsp1_data"}, rsp1_data, 0);
      chk({pfx, "_rsp1_flags"}, {rsp1_zero, rsp1_overflow}, 0);
      chk({pfx, "_alu_in0"}, alu_in0, 0);
      chk({pfx, "_alu_in1"}, alu_in1, 0);
      chk({pfx, "_alu_funct"}, alu_funct, 0);
   endtask

   // Issues one op on requester n and completes it; lat is cycles from accept to response.
   task automatic do_op(input int n, input logic [F-1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] d, output logic z, output logic o, output int lat);
      bit seen;
      d = '0; z = 1'b0; o = 1'b0; lat = -1; seen = 1'b0;
      if (n == 0) begin req0_valid = 1'b1; req0_funct = f; req0_a = a; req0_b = b; end
      else        begin req1_valid = 1'b1; req1_funct = f; req1_a = a; req1_b = b; end
      for (int t = 0; t < 10 && !seen; t++) begin
         #3;
         if ((n == 0) ? req0_ready : req1_ready) seen = 1'b1;
         step();
      end
      if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      if (!seen) begin
         chk("op_accept_timeout", 0, 1);
         return;
      end
      for (int k = 1; k <= 10 && lat < 0; k++) begin
         #3;
         if ((n == 0) ? rsp0_valid : rsp1_valid) begin
            lat = k;
            d = (n == 0) ? rsp0_data : rsp1_data;
            z = (n == 0) ? rsp0_zero : rsp1_zero;
            o = (n == 0) ? rsp0_overflow : rsp1_overflow;
            if (n == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
         end
         step();
      end
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
   endtask

   function automatic logic [F-1:0] rnd_funct();
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) return F'(r);
      return F'($urandom_range(6, 15));
   endfunction

   initial begin : p_watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : p_stim
      logic [W-1:0] d, hold;
      logic         z, o;
      int           lat, ng, seen_ok;
      int           gseq [4];

      // Reset state, with a request pending that must not see ready.
      req0_valid = 1'b1;
      @(posedge clk);
      chk_on = 1'b1;
      step(); step();
      #3;
      chk_all_zero("reset");
      req0_valid = 1'b0;
      step();
      reset_n = 1'b1;

      // Round-robin alternation with both requesters always valid.
      req0_valid = 1'b1; req0_funct = F'(1); req0_a = W'(3); req0_b = W'(3);
      req1_valid = 1'b1; req1_funct = F'(2); req1_a = W'(4); req1_b = W'(6);
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      ng = 0;
      for (int t = 0; t < 40 && ng < 4; t++) begin
         #3;
         if (req0_ready) begin gseq[ng] = 0; ng++; end
         else if (req1_ready) begin gseq[ng] = 1; ng++; end
         if (rsp0_valid) begin
            chk("rr_rsp0_data", rsp0_data, 0);
            chk("rr_rsp0_zero", rsp0_zero, 1);
         end
         if (rsp1_valid) chk("rr_rsp1_data", rsp1_data, 24);
         step();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("rr_grant_count", ng, 4);
      for (int i = 0; i < ng; i++) chk("rr_grant_order", gseq[i], i % 2);
      repeat (4) step();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;

      // Single requester ADD 5+7.
      do_op(0, F'(0), W'(5), W'(7), d, z, o, lat);
      chk("add_data", d, 12);
      chk("add_flags", {z, o}, 0);
      chk("add_latency", lat, 2);

      // Signed overflow: 1000 + 100.
      do_op(0, F'(0), W'(1000), W'(100), d, z, o, lat);
      chk("ovf_data", d, 11'h44C);
      chk("ovf_flag", o, 1);

      // Response back-pressure while the other requester waits.
      req1_valid = 1'b1; req1_funct = F'(2); req1_a = W'(9); req1_b = W'(3);
      seen_ok = 0;
      for (int t = 0; t < 10 && seen_ok == 0; t++) begin
         #3;
         if (req1_ready) seen_ok = 1;
         step();
      end
      chk("bp_accept", seen_ok, 1);
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_funct = F'(0); req0_a = W'(1); req0_b = W'(2);
      step();
      #3;
      hold = rsp1_data;
      chk("bp_rsp1_data", hold, 27);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) #3;
         chk("bp_rsp1_valid", rsp1_valid, 1);
         chk("bp_rsp1_stable", rsp1_data, hold);
         chk("bp_req0_blocked", req0_ready, 0);
         step();
      end
      rsp1_ready = 1'b1;
      #3;
      chk("bp_req0_blocked_hs", req0_ready, 0);
      step();
      rsp1_ready = 1'b0;
      #3;
      chk("bp_req0_granted", req0_ready, 1);
      chk("bp_rsp1_dropped", rsp1_valid, 0);
      step();
      req0_valid = 1'b0;
      rsp0_ready = 1'b1;
      repeat (3) step();
      rsp0_ready = 1'b0;

      // Reset during execute discards the op.
      req0_valid = 1'b1; req0_funct = F'(0); req0_a = W'(10); req0_b = W'(20);
      seen_ok = 0;
      for (int t = 0; t < 10 && seen_ok == 0; t++) begin
         #3;
         if (req0_ready) seen_ok = 1;
         step();
      end
      chk("rst_accept", seen_ok, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_all_zero("rst_exec");
      req0_valid = 1'b0;
      step(); step();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #3;
         chk("rst_no_rsp", {rsp0_valid, rsp1_valid}, 0);
         step();
      end

      // Illegal function code.
      do_op(0, F'(9), W'($urandom), W'($urandom), d, z, o, lat);
      chk("illegal_data", d, 0);
      chk("illegal_flags", {z, o}, 2'b10);
      chk("illegal_latency", lat, 2);

      // Randomized traffic against the model, including one asynchronous reset.
      for (int c = 0; c < 500; c++) begin
         req0_valid = 1'($urandom_range(0, 1));
         req1_valid = 1'($urandom_range(0, 1));
         req0_funct = rnd_funct();
         req1_funct = rnd_funct();
         req0_a = W'($urandom);
         req0_b = ($urandom_range(0, 4) == 0) ? req0_a : W'($urandom);
         req1_a = W'($urandom);
         req1_b = ($urandom_range(0, 4) == 0) ? req1_a : W'($urandom);
         rsp0_ready = ($urandom_range(0, 9) < 6);
         rsp1_ready = ($urandom_range(0, 9) < 6);
         if (c == 250) begin
            #2;
            reset_n = 1'b0;
            @(posedge clk);
            #1;
            reset_n = 1'b1;
         end else begin
            step();
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      repeat (5) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
